// File: rtl/pipe_stall_flush_ctrl_pkg.sv
// Shared constants and FSM encoding for the pipeline hazard controller.
package pipe_stall_flush_ctrl_pkg;

  localparam int STALL_BUS = 6;

  localparam int STG_PC    = 0;
  localparam int STG_IF_ID = 1;
  localparam int STG_ID_EX = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;
  localparam int STG_WB    = 5;

  typedef enum logic {
    CTRL_IDLE = 1'b0,
    CTRL_PEND = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_stall_flush_ctrl_sat_counter.sv
// Saturating event counter; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_flush_ctrl.sv
// Central hazard controller: merges stall requests into a prefix hold vector,
// sequences exception flushes around outstanding fetches, and counts events.
//
// state     | meaning
// CTRL_IDLE | normal operation; stalls follow stallreq, immediate flush allowed
// CTRL_PEND | redirect latched, pipeline frozen until fetch_busy drops
module pipe_stall_flush_ctrl
  import pipe_stall_flush_ctrl_pkg::*;
#(
  parameter int STAGES = STALL_BUS,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [STAGES-1:0] stallreq,
  input  logic              excp_req,
  input  logic [ADDR_W-1:0] excp_target,
  input  logic              fetch_busy,
  input  logic              cnt_clr,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              flush_pend,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_state_t       state, state_nxt;
  logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
  logic [STAGES-1:0] stall_mask;
  logic [STAGES-1:0] stall_c;
  logic              flush_c;
  logic [ADDR_W-1:0] new_pc_c;
  logic              req_above;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= CTRL_IDLE;
      pend_pc <= '0;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

  // Every register at or below the highest stalling stage must hold.
  always_comb begin
    req_above  = 1'b0;
    stall_mask = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      req_above     = req_above | stallreq[i];
      stall_mask[i] = req_above;
    end
  end

  always_comb begin
    state_nxt   = state;
    pend_pc_nxt = pend_pc;
    stall_c     = stall_mask;
    flush_c     = 1'b0;
    new_pc_c    = '0;
    case (state)
      CTRL_IDLE: begin
        if (excp_req && !fetch_busy) begin
          flush_c  = 1'b1;
          new_pc_c = excp_target;
          stall_c  = '0;
        end else if (excp_req) begin
          stall_c     = '1;
          pend_pc_nxt = excp_target;
          state_nxt   = CTRL_PEND;
        end
      end
      CTRL_PEND: begin
        // A younger exception here is dropped; the pending flush kills it anyway.
        if (fetch_busy) begin
          stall_c = '1;
        end else begin
          flush_c   = 1'b1;
          new_pc_c  = pend_pc;
          stall_c   = '0;
          state_nxt = CTRL_IDLE;
        end
      end
      default: state_nxt = CTRL_IDLE;
    endcase
  end

  assign stall      = resetn ? stall_c  : '0;
  assign flush      = resetn ? flush_c  : 1'b0;
  assign new_pc     = resetn ? new_pc_c : '0;
  assign flush_pend = (state == CTRL_PEND);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    ((stall != '0) && !flush),
    .clr    (cnt_clr),
    .q      (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (flush),
    .clr    (cnt_clr),
    .q      (flush_cnt)
  );

endmodule
